// File: rtl/display_digit_scanner_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment digit scanner.
// Holds the anode idle pattern, the BCD nibble width and the maximum digit count.
package display_digit_scanner_pkg;

    localparam int BCD_WIDTH  = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // Active-low one-hot anode pattern lighting digit i.
    function automatic logic [MAX_DIGITS-1:0] anode_for(input int unsigned i);
        anode_for = ~(MAX_DIGITS'(1) << i);
    endfunction

endpackage

// File: rtl/display_digit_scanner_lz_mask.sv
// Leading-zero blank mask: digit i is blanked when blanking is on, it is not
// the least significant digit, and it and every more significant nibble are zero.
module display_digit_scanner_lz_mask
    import display_digit_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [BCD_WIDTH*NUM_DIGITS-1:0] snapshot,
    input  logic                            blank_en,
    output logic [NUM_DIGITS-1:0]           blank_mask
);

    // nz_above[i] = some nibble j >= i is non-zero (suffix OR from the MSD down).
    logic [NUM_DIGITS:0] nz_above;

    assign nz_above[NUM_DIGITS] = 1'b0;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign nz_above[i]   = nz_above[i+1] | (snapshot[i*BCD_WIDTH +: BCD_WIDTH] != '0);
        assign blank_mask[i] = blank_en && (i != 0) && !nz_above[i];
    end

endmodule

// File: rtl/display_digit_scanner.sv
// Time-multiplexes a packed BCD word onto one shared 7-segment decoder,
// snapshotting the input once per frame so a frame never tears.
module display_digit_scanner
    import display_digit_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [BCD_WIDTH*NUM_DIGITS-1:0] bcd_digits,
    input  logic                            blank_en,
    output logic [BCD_WIDTH-1:0]            digit_bcd,
    output logic                            leading_zero,
    output logic [NUM_DIGITS-1:0]           anode,
    output logic                            frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int W  = BCD_WIDTH * NUM_DIGITS;

    localparam logic [NUM_DIGITS-1:0] OFF      = ANODE_OFF[NUM_DIGITS-1:0];
    localparam logic [PW-1:0]         PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         next_idx;
    logic [W-1:0]          snapshot;
    logic [W-1:0]          src;
    logic [NUM_DIGITS-1:0] mask;
    logic [MAX_DIGITS-1:0] anode_full;
    logic                  adv;
    logic                  wrap;

    assign adv        = (presc == PRE_LAST);
    assign wrap       = adv && (idx == IDX_LAST);
    assign next_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    // On the wrap cycle digit 0 is fed straight from the input, matching the new snapshot.
    assign src        = wrap ? bcd_digits : snapshot;
    assign anode_full = anode_for(32'(next_idx));

    display_digit_scanner_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .snapshot   (src),
        .blank_en   (blank_en),
        .blank_mask (mask)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc        <= '0;
            idx          <= IDX_LAST;
            snapshot     <= '0;
            digit_bcd    <= '0;
            leading_zero <= 1'b0;
            anode        <= OFF;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            presc      <= adv ? '0 : presc + 1'b1;
            if (adv) begin
                idx          <= next_idx;
                digit_bcd    <= src[next_idx*BCD_WIDTH +: BCD_WIDTH];
                leading_zero <= mask[next_idx];
                anode        <= anode_full[NUM_DIGITS-1:0];
                frame_tick   <= wrap;
                if (wrap)
                    snapshot <= bcd_digits;
            end
        end
    end

endmodule

// File: tb/tb_display_digit_scanner.sv
// Bench for display_digit_scanner: two instances (REFRESH_DIV 3 and 1), each with
// a frame-level reference model feeding a scoreboard that a separate monitor drains.
module tb_display_digit_scanner;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] bcd;
        logic       lz;
        logic       ft;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0][15:0] bcd;
    logic [1:0]       blk;
    wire  [1:0][3:0]  an;
    wire  [1:0][3:0]  db;
    wire  [1:0]       lz;
    wire  [1:0]       ft;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int RD = (g == 0) ? 3 : 1;

        exp_t        q[$];
        int          cyc;
        int          kadv;
        logic [15:0] frame;
        logic [3:0]  prev;
        int          hold;

        display_digit_scanner #(
            .NUM_DIGITS  (4),
            .REFRESH_DIV (RD)
        ) dut (
            .clk          (clk),
            .reset        (reset),
            .bcd_digits   (bcd[g]),
            .blank_en     (blk[g]),
            .digit_bcd    (db[g]),
            .leading_zero (lz[g]),
            .anode        (an[g]),
            .frame_tick   (ft[g])
        );

        // Reference: every RD-th clock after release lights the next digit in
        // order 0,1,2,3; a frame's value is the input seen when digit 0 lights.
        always @(posedge clk) begin
            if (reset) begin
                cyc  = 0;
                kadv = 0;
                q.delete();
            end else begin
                cyc++;
                if (cyc % RD == 0) begin
                    int   d;
                    exp_t e;
                    d = kadv % 4;
                    if (d == 0) frame = bcd[g];
                    e.an  = ~(4'b0001 << d);
                    e.bcd = 4'((frame >> (4 * d)) & 16'hF);
                    e.lz  = blk[g] && (d != 0) && ((frame >> (4 * d)) == 16'h0);
                    e.ft  = (d == 0);
                    q.push_back(e);
                    kadv++;
                end
            end
        end

        always @(negedge clk) begin
            if (reset) begin
                check($sformatf("reset_state%0d", g), {an[g], db[g], lz[g], ft[g]}, {4'hF, 4'h0, 2'b00});
                q.delete();
                prev = 4'hF;
                hold = 0;
            end else if (an[g] != prev) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output%0d: anode %b with empty queue", g, an[g]);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check($sformatf("digit%0d", g), {an[g], db[g], lz[g], ft[g]}, {e.an, e.bcd, e.lz, e.ft});
                end
                if (prev != 4'hF)
                    check($sformatf("hold_len%0d", g), hold, RD);
                prev = an[g];
                hold = 1;
            end else begin
                hold++;
                check($sformatf("tick_width%0d", g), ft[g], 1'b0);
                if (hold > RD + 1) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stalled%0d: anode %b held %0d cycles, limit %0d", g, an[g], hold, RD);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic wait_lit0(input logic [3:0] pat);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an[0] == pat) begin
                #2;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_anode: never saw %b, last %b", pat, an[0]);
    endtask

    // Release at negedge+2; digit 0 must light on the third rising edge.
    task automatic release_and_check;
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_first_adv", an[0], 4'hF);
        @(posedge clk);
        @(negedge clk);
        check("first_adv_anode", {an[0], ft[0]}, {4'b1110, 1'b1});
        @(posedge clk);
        @(negedge clk);
        check("first_tick_drop", ft[0], 1'b0);
        #2;
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int i = 0; i < 4; i++)
            w[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        return w;
    endfunction

    initial begin
        bcd   = {16'h0A05, 16'h0042};
        blk   = 2'b11;
        reset = 1'b1;
        cycles(3);
        release_and_check();

        cycles(30);
        bcd[0] = 16'h0000;
        cycles(26);
        blk[0] = 1'b0;
        cycles(26);

        blk[0] = 1'b1;
        bcd[0] = 16'h1234;
        wait_lit0(4'b1110);
        wait_lit0(4'b1101);
        bcd[0] = 16'h5678;
        cycles(30);

        wait_lit0(4'b1011);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("async_reset", {an[0], db[0], lz[0], an[1], db[1], lz[1]},
                 {4'hF, 4'h0, 1'b0, 4'hF, 4'h0, 1'b0});
        cycles(3);
        release_and_check();

        for (int f = 0; f < 40; f++) begin
            bcd[0] = rand_word();
            bcd[1] = rand_word();
            repeat ($urandom_range(1, 12)) begin
                cycles(1);
                if ($urandom_range(0, 3) == 0) blk = 2'($urandom);
            end
        end

        cycles(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
